// File: rtl/ctl_gun_shot.sv
`timescale 1ns/1ps
// ctl_gun_shot: one Duck Hunt light-gun shot -- trigger debounce, black/target flash frames,
// hit/miss decision and per-round ammo. Define DH_BLACK_CHECK_EN to reject light seen during the black frame.
module ctl_gun_shot #(
  parameter int DEBOUNCE_CYCLES = 65000,
  parameter int PD_MIN_CYCLES   = 16,
  parameter int COOLDOWN_FRAMES = 10,
  parameter int AMMO            = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       new_frame,
  input  logic       round_start,
  input  logic       duck_show,
  input  logic       gun_trigger,
  input  logic       gun_photodetector,
  output logic       flash_black,
  output logic       flash_target,
  output logic       duck_hit,
  output logic       shot_miss,
  output logic [2:0] ammo,
  output logic       busy
);

  localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int PD_W = $clog2(PD_MIN_CYCLES + 1);
  localparam int CD_W = $clog2(COOLDOWN_FRAMES + 1);

  localparam logic [DB_W-1:0] DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [PD_W-1:0] PD_FULL   = PD_W'(PD_MIN_CYCLES);
  localparam logic [CD_W-1:0] CD_FULL   = CD_W'(COOLDOWN_FRAMES);
  localparam logic [2:0]      AMMO_FULL = 3'(AMMO);

  typedef enum logic [2:0] {
    IDLE,
    ARM,
    BLACK,
    TARGET,
    RESOLVE,
    COOLDOWN
  } state_t;

  state_t            state, state_next;
  logic              trig_meta, trig_sync, pd_meta, pd_sync;
  logic              trig_db, trig_db_d, trig_edge;
  logic [DB_W-1:0]   db_cnt;
  logic [PD_W-1:0]   pd_cnt;
  logic              light_seen, pd_clear;
  logic              hit_flag, hit_next;
  logic              cheat_flag, cheat_next;
  logic [CD_W-1:0]   cd_cnt, cd_next;
  logic [2:0]        ammo_next;

  // Synchronizers and trigger debounce; the debounced level only moves after a full stable run.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      trig_meta <= 1'b0;
      trig_sync <= 1'b0;
      pd_meta   <= 1'b0;
      pd_sync   <= 1'b0;
      trig_db   <= 1'b0;
      trig_db_d <= 1'b0;
      db_cnt    <= '0;
    end else begin
      trig_meta <= gun_trigger;
      trig_sync <= trig_meta;
      pd_meta   <= gun_photodetector;
      pd_sync   <= pd_meta;
      trig_db_d <= trig_db;
      if (trig_sync == trig_db) begin
        db_cnt <= '0;
      end else if (db_cnt == DB_LAST) begin
        trig_db <= trig_sync;
        db_cnt  <= '0;
      end else begin
        db_cnt <= db_cnt + 1'b1;
      end
    end
  end

  assign trig_edge = trig_db & ~trig_db_d;

  // A light run must lie entirely inside one flash frame, so the counter restarts on frame entry.
  assign pd_clear   = (state_next != state) && ((state_next == BLACK) || (state_next == TARGET));
  assign light_seen = (pd_cnt == PD_FULL);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pd_cnt <= '0;
    end else if (pd_clear || !pd_sync) begin
      pd_cnt <= '0;
    end else if (pd_cnt != PD_FULL) begin
      pd_cnt <= pd_cnt + 1'b1;
    end
  end

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latches).
  always_comb begin
    state_next = state;
    hit_next   = hit_flag;
    cheat_next = cheat_flag;
    cd_next    = cd_cnt;
    ammo_next  = ammo;

    case (state)
      IDLE: begin
        if (trig_edge && (ammo != 3'd0)) begin
          state_next = ARM;
          ammo_next  = ammo - 3'd1;
        end
      end
      ARM: begin
        if (new_frame) begin
          if (duck_show) begin
            state_next = BLACK;
          end else begin
            state_next = RESOLVE;
            hit_next   = 1'b0;
          end
        end
      end
      BLACK: begin
`ifdef DH_BLACK_CHECK_EN
        if (light_seen) cheat_next = 1'b1;
`endif
        if (new_frame) state_next = TARGET;
      end
      TARGET: begin
        if (light_seen) hit_next = 1'b1;
        if (new_frame) state_next = RESOLVE;
      end
      RESOLVE: begin
        hit_next   = 1'b0;
        cheat_next = 1'b0;
        cd_next    = '0;
        state_next = COOLDOWN;
      end
      COOLDOWN: begin
        if (new_frame && (cd_cnt != CD_FULL)) cd_next = cd_cnt + 1'b1;
        // A held trigger parks here; release is required before another shot.
        if ((cd_cnt == CD_FULL) && !trig_db) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase

    // A new round aborts everything, including a trigger edge in this same cycle.
    if (round_start) begin
      state_next = IDLE;
      hit_next   = 1'b0;
      cheat_next = 1'b0;
      cd_next    = '0;
      ammo_next  = AMMO_FULL;
    end
  end

  // Outputs are registered from next-state so they line up exactly with the state they describe.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      hit_flag     <= 1'b0;
      cheat_flag   <= 1'b0;
      cd_cnt       <= '0;
      ammo         <= AMMO_FULL;
      flash_black  <= 1'b0;
      flash_target <= 1'b0;
      duck_hit     <= 1'b0;
      shot_miss    <= 1'b0;
    end else begin
      state        <= state_next;
      hit_flag     <= hit_next;
      cheat_flag   <= cheat_next;
      cd_cnt       <= cd_next;
      ammo         <= ammo_next;
      flash_black  <= (state_next == BLACK);
      flash_target <= (state_next == TARGET);
      duck_hit     <= (state_next == RESOLVE) && hit_next && !cheat_next;
      shot_miss    <= (state_next == RESOLVE) && !(hit_next && !cheat_next);
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: doc/ctl_gun_shot.md
Name: ctl_gun_shot

Overview:
- Sequences one light-gun shot for Duck Hunt.
- On a debounced trigger press it asks the VGA draw chain to blank one full frame, then draws a white target box at the duck for one frame.
- It samples the photodetector during both frames and reports hit or miss to ctl_duck.
- It also tracks ammo per round.
- Sits in the ctrl section of top_DH, in the 65 MHz clk domain, beside ctl_duck; its flash outputs feed draw_duck.

Parameters:
- DEBOUNCE_CYCLES, 65000: consecutive stable synced-trigger cycles needed to accept a level change (1 ms at 65 MHz).
- PD_MIN_CYCLES, 16: consecutive photodetector-high cycles that count as "light seen".
- COOLDOWN_FRAMES, 10: frames after resolve during which the trigger is ignored.
- AMMO, 3: shots per round. Range 1..7.

Ports:
- clk, input, 1: 65 MHz pixel clock.
- rst, input, 1: asynchronous, active-low reset.
- new_frame, input, 1: 1-cycle pulse at frame start, from vga_timing.
- round_start, input, 1: 1-cycle pulse; reloads ammo and aborts any shot.
- duck_show, input, 1: duck currently visible.
- gun_trigger, input, 1: raw trigger, active high, asynchronous.
- gun_photodetector, input, 1: raw sensor, high = light, asynchronous.
- flash_black, output, 1: draw stage outputs black full-screen.
- flash_target, output, 1: draw stage outputs black screen with a white duck-sized box at the duck position.
- duck_hit, output, 1: 1-cycle hit pulse.
- shot_miss, output, 1: 1-cycle miss pulse.
- ammo, output, 3: shots remaining.
- busy, output, 1: high in every state except IDLE.

Behaviour:
- Reset values: flash_black=0, flash_target=0, duck_hit=0, shot_miss=0, ammo=AMMO, busy=0, FSM=IDLE, all counters 0.
- Input conditioning:
  - gun_trigger and gun_photodetector each pass through a 2-FF synchronizer.
  - Trigger debounce: the debounced level flips only after DEBOUNCE_CYCLES consecutive synced samples differ from it. The counter clears on any matching sample.
  - trig_edge is a 1-cycle pulse on a 0→1 transition of the debounced level.
  - Photodetector run counter counts consecutive synced-high cycles and saturates at PD_MIN_CYCLES. light_seen = (count == PD_MIN_CYCLES).
- FSM states: IDLE, ARM, BLACK, TARGET, RESOLVE, COOLDOWN.
- IDLE:
  - trig_edge with ammo>0 → ARM; ammo decrements in the same cycle.
  - trig_edge with ammo==0 is ignored.
- ARM: on new_frame, go to BLACK if duck_show=1, otherwise go to RESOLVE with the hit flag forced to 0.
- BLACK:
  - flash_black=1 from the cycle after entry.
  - If light_seen occurs, cheat_flag=1.
  - On new_frame → TARGET.
- TARGET:
  - flash_target=1, flash_black=0.
  - If light_seen occurs, hit_flag=1.
  - On new_frame → RESOLVE.
- RESOLVE (one cycle):
  - Flash outputs = 0.
  - duck_hit=1 if hit_flag & ~cheat_flag, else shot_miss=1.
  - Clear both flags and the cooldown counter → COOLDOWN.
- COOLDOWN:
  - Counts new_frame pulses.
  - When the count reaches COOLDOWN_FRAMES and the debounced trigger is low → IDLE.
  - A held trigger keeps the FSM in COOLDOWN with no auto-fire.
- Latency: trigger edge to result is 2 to 3 frames, resolving on the 3rd new_frame after ARM entry.
- Boundary rules:
  - round_start in any state → IDLE next cycle; flash outputs, flags and pulses = 0; ammo=AMMO.
  - round_start has priority over a simultaneous trig_edge, which is discarded.
  - A trig_edge while busy is ignored (no queueing).
  - The photodetector counter clears on entry to BLACK and to TARGET, so a run never spans a state boundary.
  - new_frame arriving in the same cycle as the IDLE→ARM transition is not consumed; ARM waits for the next new_frame.
  - duck_hit and shot_miss are never both high, and each is exactly 1 cycle wide.
  - ammo never underflows.
  - Async reset mid-shot: all outputs return to reset values immediately.

Optional Feature:
- Macro: DH_BLACK_CHECK_EN.
- Defined: cheat_flag is set by light_seen during BLACK and forces a miss, rejecting a gun pointed at a lamp.
- Undefined: the BLACK frame is still displayed, but the photodetector is ignored there; cheat_flag stays 0. The hit decision uses only TARGET.

Test Plan:
Bench parameters: DEBOUNCE_CYCLES=4, PD_MIN_CYCLES=2, COOLDOWN_FRAMES=2, AMMO=3; new_frame every 100 cycles.
- Hit path: duck_show=1; trigger high for 10 cycles; photodetector high 5 cycles mid-TARGET → flash_black for 1 frame, then flash_target for 1 frame, then duck_hit for 1 cycle; ammo 3→2; busy low after 2 further frames.
- Miss and bounce: trigger toggles every 2 cycles for 20 cycles, then stays low → no ARM entry. Then a clean press with photodetector low → shot_miss pulse, duck_hit never asserted.
- Glitch and cheat: a 1-cycle photodetector pulse in TARGET → miss. With DH_BLACK_CHECK_EN, photodetector high throughout BLACK and TARGET → miss; without the macro, the same stimulus → hit.
- Ammo: 4 clean presses spaced past cooldown → 3 results, ammo reaches 0, 4th press gives busy=0 and no pulse. round_start → ammo=3.
- Abort and hold: round_start during TARGET → flash_target=0 next cycle, no result pulse, ammo=3. Trigger held through COOLDOWN → stays in COOLDOWN until release.
- Async reset asserted during BLACK → flash_black=0 immediately, ammo=3.
